// File: rtl/simplerisc_pkg.sv
// Shared constants and types for the register-file writeback path.
// Holds the register-file geometry, the arbiter FSM states and the buffered late-result entry.
package simplerisc_pkg;

    localparam int NUM_REGS   = 16;
    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] RA_REG = 4'd15;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the pipeline/late unit/decode side and the writeback port arbiter.
// The master drives requests; the slave is the arbiter.
interface wb_port_arbiter_if;
    import simplerisc_pkg::*;

    logic                  pipe_valid;
    logic [REG_ADDR_W-1:0] pipe_rd;
    logic [DATA_W-1:0]     pipe_data;
    logic                  pipe_stall;

    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_rd;
    logic [DATA_W-1:0]     lu_data;
    logic                  lu_ready;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [NUM_REGS-1:0]   busy_mask;

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;

    modport master (
        output pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data, issue_valid, issue_rd,
        input  pipe_stall, lu_ready, busy_mask, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data, issue_valid, issue_rd,
        output pipe_stall, lu_ready, busy_mask, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/wb_late_fifo.sv
// Circular buffer holding late-unit results until the write port is free.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_late_fifo
    import simplerisc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  wb_entry_t                  i_push_entry,
    input  logic                       i_pop,
    output wb_entry_t                  o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // NOTE: storage has no reset; the count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between in-order writeback and buffered late results.
// A DRAIN state stalls the pipeline when the buffer fills or a late result has waited too long.
module wb_port_arbiter
    import simplerisc_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t            r_state;
    logic [AGE_W-1:0]      r_age;
    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  r_wr_src;
    logic [NUM_REGS-1:0]   r_busy;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_grant_pipe;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      w_count_next;
    logic [AGE_W-1:0]      w_age_next;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;
    wb_entry_t             w_push_entry;
    wb_entry_t             w_head;

    assign w_push       = bus.lu_valid & ~w_full;
    assign w_push_entry = '{rd: bus.lu_rd, data: bus.lu_data};

    wb_late_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_grant_pipe = 1'b0;
        w_pop        = 1'b0;
        if (r_state == NORMAL && bus.pipe_valid) begin
            w_grant_pipe = 1'b1;
        end else begin
            w_pop = ~w_empty;
        end
    end

    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_comb begin
        w_age_next = r_age;
        if (w_pop || w_empty) begin
            w_age_next = '0;
        end else if (r_age != AGE_W'(STARVE_LIMIT)) begin
            w_age_next = r_age + AGE_W'(1);
        end
    end

    // A late write clears its bit at the edge the register file commits it; a same-edge issue wins.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (bus.issue_valid)     w_set[bus.issue_rd] = 1'b1;
        if (r_wr_en && r_wr_src) w_clr[r_wr_addr]    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= NORMAL;
            r_age     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_src  <= 1'b0;
            r_busy    <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;

            if (w_grant_pipe) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= bus.pipe_rd;
                r_wr_data <= bus.pipe_data;
                r_wr_src  <= 1'b0;
            end else if (w_pop) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_head.rd;
                r_wr_data <= w_head.data;
                r_wr_src  <= 1'b1;
            end else begin
                r_wr_en <= 1'b0;
            end

            if (r_state == NORMAL) begin
                if (w_count_next == CNT_W'(DEPTH) || w_age_next == AGE_W'(STARVE_LIMIT)) begin
                    r_state <= DRAIN;
                    r_age   <= '0;
                end else begin
                    r_age <= w_age_next;
                end
            end else begin
                r_age <= '0;
                if (w_count_next == '0) r_state <= NORMAL;
            end
        end
    end

    assign bus.pipe_stall = (r_state == DRAIN);
    assign bus.lu_ready   = ~w_full;
    assign bus.busy_mask  = r_busy;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, a wrap-around sequence,
// then random traffic scored against a queue-based model of the port rules.
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int N_RANDOM     = 3000;

    typedef struct packed {
        logic        rst;
        logic        pv;
        logic [3:0]  prd;
        logic [31:0] pdata;
        logic        lv;
        logic [3:0]  lrd;
        logic [31:0] ldata;
        logic        iv;
        logic [3:0]  ird;
    } in_t;

    typedef struct packed {
        logic        wen;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic        stall;
        logic        ready;
        logic [15:0] busy;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl [$];

    // Reference model state: an ordered queue of waiting results plus plain flags and counters.
    ent_t        m_q [$];
    bit          m_drain;
    int          m_age;
    logic        m_wen;
    logic [3:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_late;
    logic [15:0] m_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input logic rst, input logic pv, input logic [3:0] prd,
                               input logic [31:0] pdata, input logic lv, input logic [3:0] lrd,
                               input logic [31:0] ldata, input logic iv, input logic [3:0] ird);
        in_t v;
        v = '{rst, pv, prd, pdata, lv, lrd, ldata, iv, ird};
        return v;
    endfunction

    task automatic row(input logic rst, input logic pv, input logic [3:0] prd, input logic [31:0] pdata,
                       input logic lv, input logic [3:0] lrd, input logic [31:0] ldata,
                       input logic iv, input logic [3:0] ird,
                       input logic wen, input logic [3:0] waddr, input logic [31:0] wdata,
                       input logic stall, input logic ready, input logic [15:0] busy);
        vec_t v;
        v.i = mk(rst, pv, prd, pdata, lv, lrd, ldata, iv, ird);
        v.o = '{wen, waddr, wdata, stall, ready, busy};
        tbl.push_back(v);
    endtask

    task automatic apply(input in_t v);
        reset           = v.rst;
        bus.pipe_valid  = v.pv;
        bus.pipe_rd     = v.prd;
        bus.pipe_data   = v.pdata;
        bus.lu_valid    = v.lv;
        bus.lu_rd       = v.lrd;
        bus.lu_data     = v.ldata;
        bus.issue_valid = v.iv;
        bus.issue_rd    = v.ird;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input out_t e);
        check({tag, ".wr_en"},      32'(bus.wr_en),      32'(e.wen));
        check({tag, ".wr_addr"},    32'(bus.wr_addr),    32'(e.waddr));
        check({tag, ".wr_data"},    bus.wr_data,         e.wdata);
        check({tag, ".pipe_stall"}, 32'(bus.pipe_stall), 32'(e.stall));
        check({tag, ".lu_ready"},   32'(bus.lu_ready),   32'(e.ready));
        check({tag, ".busy_mask"},  32'(bus.busy_mask),  32'(e.busy));
    endtask

    task automatic model_step(input in_t v, output out_t e);
        int   n;
        bit   push;
        bit   pipe_win;
        bit   pop;
        ent_t h;
        if (v.rst) begin
            m_q.delete();
            m_drain = 0;
            m_age   = 0;
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_late  = 0;
            m_busy  = '0;
        end else begin
            n        = m_q.size();
            push     = v.lv && (n < DEPTH);
            pipe_win = !m_drain && v.pv;
            pop      = !pipe_win && (n > 0);
            if (m_wen && m_late) m_busy[m_waddr] = 1'b0;
            if (v.iv) m_busy[v.ird] = 1'b1;
            if (pipe_win) begin
                m_wen = 1'b1; m_waddr = v.prd; m_wdata = v.pdata; m_late = 0;
            end else if (pop) begin
                h = m_q.pop_front();
                m_wen = 1'b1; m_waddr = h.rd; m_wdata = h.data; m_late = 1;
            end else begin
                m_wen = 1'b0;
            end
            if (push) m_q.push_back('{rd: v.lrd, data: v.ldata});
            if (!m_drain) begin
                if (pop || n == 0) m_age = 0;
                else if (m_age < STARVE_LIMIT) m_age++;
                if (m_q.size() == DEPTH || m_age >= STARVE_LIMIT) begin
                    m_drain = 1;
                    m_age   = 0;
                end
            end else if (m_q.size() == 0) begin
                m_drain = 0;
            end
        end
        e = '{m_wen, m_waddr, m_wdata, m_drain, (m_q.size() < DEPTH), m_busy};
    endtask

    initial begin
        in_t  idle;
        in_t  v;
        out_t e;
        int   dens;

        total = 0;
        bad   = 0;
        idle  = mk(0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0);

        // Reset held two cycles with busy inputs, then pipe-only traffic.
        row(1, 1, 4'd3,  32'hDEAD_0001, 1, 4'd7, 32'h0000_1111, 1, 4'd7,  0, 4'd0,  32'h0,         0, 1, 16'h0000);
        row(1, 0, 4'd9,  32'hDEAD_0002, 1, 4'd2, 32'h0000_2222, 1, 4'd9,  0, 4'd0,  32'h0,         0, 1, 16'h0000);
        row(0, 1, 4'd3,  32'hA5A5_0001, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd3,  32'hA5A5_0001, 0, 1, 16'h0000);
        row(0, 1, 4'd3,  32'hA5A5_0002, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd3,  32'hA5A5_0002, 0, 1, 16'h0000);
        row(0, 1, 4'd4,  32'hA5A5_0003, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd4,  32'hA5A5_0003, 0, 1, 16'h0000);
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         0, 4'd0,  0, 4'd4,  32'hA5A5_0003, 0, 1, 16'h0000);
        // Idle drain of a single late result for r7.
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         1, 4'd7,  0, 4'd4,  32'hA5A5_0003, 0, 1, 16'h0080);
        row(0, 0, 4'd0,  32'h0,         1, 4'd7, 32'h0000_1234, 0, 4'd0,  0, 4'd4,  32'hA5A5_0003, 0, 1, 16'h0080);
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd7,  32'h0000_1234, 0, 1, 16'h0080);
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         0, 4'd0,  0, 4'd7,  32'h0000_1234, 0, 1, 16'h0000);
        // Buffer fills behind continuous pipe traffic.
        row(0, 1, 4'd10, 32'h0000_00B0, 1, 4'd1, 32'h0000_0011, 0, 4'd0,  1, 4'd10, 32'h0000_00B0, 0, 1, 16'h0000);
        row(0, 1, 4'd10, 32'h0000_00B1, 1, 4'd2, 32'h0000_0022, 0, 4'd0,  1, 4'd10, 32'h0000_00B1, 1, 0, 16'h0000);
        row(0, 1, 4'd10, 32'h0000_00B2, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd1,  32'h0000_0011, 1, 1, 16'h0000);
        row(0, 1, 4'd10, 32'h0000_00B2, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd2,  32'h0000_0022, 0, 1, 16'h0000);
        row(0, 1, 4'd10, 32'h0000_00B2, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd10, 32'h0000_00B2, 0, 1, 16'h0000);
        // Starvation of one late result for r9.
        row(0, 1, 4'd11, 32'h0000_00C0, 1, 4'd9, 32'h0000_0099, 0, 4'd0,  1, 4'd11, 32'h0000_00C0, 0, 1, 16'h0000);
        row(0, 1, 4'd11, 32'h0000_00C1, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd11, 32'h0000_00C1, 0, 1, 16'h0000);
        row(0, 1, 4'd11, 32'h0000_00C2, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd11, 32'h0000_00C2, 0, 1, 16'h0000);
        row(0, 1, 4'd11, 32'h0000_00C3, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd11, 32'h0000_00C3, 0, 1, 16'h0000);
        row(0, 1, 4'd11, 32'h0000_00C4, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd11, 32'h0000_00C4, 1, 1, 16'h0000);
        row(0, 1, 4'd11, 32'h0000_00C5, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd9,  32'h0000_0099, 0, 1, 16'h0000);
        row(0, 1, 4'd11, 32'h0000_00C6, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd11, 32'h0000_00C6, 0, 1, 16'h0000);
        // Re-issue to r5 on the edge its late write retires.
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         1, 4'd5,  0, 4'd11, 32'h0000_00C6, 0, 1, 16'h0020);
        row(0, 0, 4'd0,  32'h0,         1, 4'd5, 32'h0000_0055, 0, 4'd0,  0, 4'd11, 32'h0000_00C6, 0, 1, 16'h0020);
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd5,  32'h0000_0055, 0, 1, 16'h0020);
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         1, 4'd5,  0, 4'd5,  32'h0000_0055, 0, 1, 16'h0020);
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         0, 4'd0,  0, 4'd5,  32'h0000_0055, 0, 1, 16'h0020);
        // Reset while draining two entries.
        row(0, 1, 4'd12, 32'h0000_00D0, 1, 4'd1, 32'h0000_00E1, 0, 4'd0,  1, 4'd12, 32'h0000_00D0, 0, 1, 16'h0020);
        row(0, 1, 4'd12, 32'h0000_00D1, 1, 4'd2, 32'h0000_00E2, 0, 4'd0,  1, 4'd12, 32'h0000_00D1, 1, 0, 16'h0020);
        row(1, 1, 4'd12, 32'h0000_00D2, 0, 4'd0, 32'h0,         0, 4'd0,  0, 4'd0,  32'h0,         0, 1, 16'h0000);
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         0, 4'd0,  0, 4'd0,  32'h0,         0, 1, 16'h0000);
        row(0, 0, 4'd0,  32'h0,         0, 4'd0, 32'h0,         0, 4'd0,  0, 4'd0,  32'h0,         0, 1, 16'h0000);
        row(0, 1, 4'd6,  32'h0000_00F0, 0, 4'd0, 32'h0,         0, 4'd0,  1, 4'd6,  32'h0000_00F0, 0, 1, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].i);
            cmp($sformatf("vec%0d", i), tbl[i].o);
        end

        // Push on the edge of what would be the last drain pop; buffer pointers wrap here.
        apply(mk(1, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0));
        apply(mk(0, 1, 4'd1, 32'h0000_0001, 1, 4'd3, 32'h0000_0030, 0, 4'd0));
        apply(mk(0, 1, 4'd1, 32'h0000_0002, 1, 4'd4, 32'h0000_0040, 0, 4'd0));
        check("wrap.stall_on_full", 32'(bus.pipe_stall), 32'd1);
        check("wrap.ready_on_full", 32'(bus.lu_ready),   32'd0);
        apply(idle);
        check("wrap.first_pop_addr", 32'(bus.wr_addr),   32'd3);
        check("wrap.first_pop_data", bus.wr_data,        32'h0000_0030);
        apply(mk(0, 0, 4'd0, 32'h0, 1, 4'd5, 32'h0000_0050, 0, 4'd0));
        check("wrap.pushpop_addr",   32'(bus.wr_addr),   32'd4);
        check("wrap.pushpop_data",   bus.wr_data,        32'h0000_0040);
        check("wrap.still_drain",    32'(bus.pipe_stall), 32'd1);
        check("wrap.ready_mid",      32'(bus.lu_ready),  32'd1);
        apply(idle);
        check("wrap.wrapped_en",     32'(bus.wr_en),     32'd1);
        check("wrap.wrapped_addr",   32'(bus.wr_addr),   32'd5);
        check("wrap.wrapped_data",   bus.wr_data,        32'h0000_0050);
        check("wrap.drain_done",     32'(bus.pipe_stall), 32'd0);
        apply(idle);
        check("wrap.idle_no_write",  32'(bus.wr_en),     32'd0);

        // Random traffic against the model, with varying pipe density to provoke starvation.
        dens = 50;
        v = mk(1, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0);
        model_step(v, e);
        apply(v);
        cmp("rnd_reset", e);
        for (int c = 0; c < N_RANDOM; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       dens = 20;
                    1:       dens = 60;
                    default: dens = 95;
                endcase
            end
            v.rst   = ($urandom_range(0, 99) == 0);
            v.pv    = ($urandom_range(0, 99) < dens);
            v.prd   = 4'($urandom_range(0, 15));
            v.pdata = $urandom();
            v.lv    = ($urandom_range(0, 99) < 40);
            v.lrd   = 4'($urandom_range(0, 15));
            v.ldata = $urandom();
            v.iv    = ($urandom_range(0, 99) < 25);
            v.ird   = 4'($urandom_range(0, 15));
            model_step(v, e);
            apply(v);
            cmp($sformatf("rnd%0d", c), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
